// File: rtl/word_to_byte_stream.sv
// FIFO-buffered word-to-byte serialiser feeding the FTDI FT245 write port.
// Words are queued, then emitted one byte per cycle whenever ftdi_full is low.
module word_to_byte_stream #(
  parameter int IN_WIDTH  = 64,
  parameter int DEPTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk_pll,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       din,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic                      ftdi_full,
  output logic                      ftdi_wr_en,
  output logic [7:0]                ftdi_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow
);

  localparam int NBYTES = IN_WIDTH / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  logic [IN_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [IN_WIDTH-1:0] rd_data;
  logic [IN_WIDTH-1:0] word_q;

  state_t        state_q;
  state_t        state_n;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_n;
  logic          push;
  logic          pop;
  logic          load;
  logic          has_word;
  logic          wr_n;
  logic [7:0]    data_n;
  logic [7:0]    byte_arr [NBYTES];
  logic [7:0]    cur_byte;

  assign din_ready = (fifo_level != LVL_FULL);
  assign push      = din_valid && din_ready;
  assign has_word  = (fifo_level != '0);

  always_ff @(posedge clk_pll) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk_pll) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      rd_data    <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - 1'b1;
      end
      if (din_valid && !din_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Byte lane order is fixed at elaboration; idx always counts 0..NBYTES-1.
  always_comb begin
    for (int i = 0; i < NBYTES; i++) begin
      if (MSB_FIRST) begin
        byte_arr[i] = word_q[IN_WIDTH-1-8*i -: 8];
      end else begin
        byte_arr[i] = word_q[8*i +: 8];
      end
    end
  end

  assign cur_byte = byte_arr[idx_q];

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    pop     = 1'b0;
    load    = 1'b0;
    wr_n    = 1'b0;
    data_n  = ftdi_data;
    case (state_q)
      IDLE: begin
        if (has_word) begin
          pop     = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        idx_n   = '0;
        state_n = SEND;
      end
      SEND: begin
        if (!ftdi_full) begin
          wr_n   = 1'b1;
          data_n = cur_byte;
          idx_n  = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_n = '0;
            if (has_word) begin
              pop     = 1'b1;
              state_n = LOAD;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pll) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      word_q     <= '0;
      ftdi_wr_en <= 1'b0;
      ftdi_data  <= 8'h00;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      ftdi_wr_en <= wr_n;
      ftdi_data  <= data_n;
      if (load) begin
        word_q <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_word_to_byte_stream.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share stimulus;
// accepted words are expanded into expected byte queues and checked at output.
module tb_word_to_byte_stream;

  localparam int W     = 64;
  localparam int DEPTH = 16;
  localparam int NB    = W / 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         ftdi_full;

  logic         rdy0, rdy1;
  logic         wr0, wr1;
  logic [7:0]   dat0, dat1;
  logic [4:0]   lvl0, lvl1;
  logic         ovf0, ovf1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  word_to_byte_stream #(.IN_WIDTH(W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut0 (
    .clk_pll(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .ftdi_full(ftdi_full), .ftdi_wr_en(wr0),
    .ftdi_data(dat0), .fifo_level(lvl0), .overflow(ovf0)
  );

  word_to_byte_stream #(.IN_WIDTH(W), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut1 (
    .clk_pll(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .ftdi_full(ftdi_full), .ftdi_wr_en(wr1),
    .ftdi_data(dat1), .fifo_level(lvl1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th byte on the wire: counted from the top byte or the bottom byte.
  function automatic logic [7:0] wire_byte(input logic [W-1:0] w,
                                           input int k, input bit msb);
    int pos;
    logic [W-1:0] s;
    pos = msb ? (NB - 1 - k) : k;
    s = w >> (8 * pos);
    return s[7:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && din_valid && rdy0)
      for (int k = 0; k < NB; k++) q0.push_back(wire_byte(din, k, 1'b1));
    if (!rst && din_valid && rdy1)
      for (int k = 0; k < NB; k++) q1.push_back(wire_byte(din, k, 1'b0));
  end

  always @(negedge clk) begin
    if (wr0) begin
      if (q0.size() == 0) chk("dut0_unexpected_byte", 0, 1);
      else chk("dut0_byte", dat0, q0.pop_front());
    end
    if (wr1) begin
      if (q1.size() == 0) chk("dut1_unexpected_byte", 0, 1);
      else chk("dut1_byte", dat1, q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && lvl0 == 0 && lvl1 == 0) break;
      tick();
    end
    tick();
    tick();
    chk({name, "_q_left"}, 64'(q0.size() + q1.size()), 0);
    chk({name, "_level"}, lvl0, 0);
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [39:0] rec;
    logic [39:0] exp_rec;
    int cnt;
    bit found;

    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    ftdi_full = 1'b0;
    tick();
    tick();
    chk("rst_wr_en", wr0, 0);
    chk("rst_data", dat0, 8'h00);
    chk("rst_level", lvl0, 0);
    chk("rst_overflow", ovf0, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", rdy0, 1);

    // Latency and byte order of a single word
    push_word(64'h0102030405060708);
    tick();
    chk("lat_t1", wr0, 0);
    tick();
    chk("lat_t2", wr0, 0);
    tick();
    chk("lat_t3_wr", wr0, 1);
    chk("lat_t3_msb", dat0, 8'h01);
    chk("lat_t3_lsb", dat1, 8'h08);
    drain("t1");

    // Three words back to back: one bubble between words
    for (int i = 0; i < 3; i++) begin
      din       = rnd_word();
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      rec[i] = wr0;
    end
    for (int i = 0; i < 40; i++) exp_rec[i] = (i < 26) && (i != 8) && (i != 17);
    chk("b2b_wr_pattern", rec, exp_rec);
    drain("t3");

    // Stall for 5 cycles after the third byte
    push_word(rnd_word());
    cnt   = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (wr0) cnt++;
      if (cnt == 3) found = 1;
    end
    chk("stall_found_byte3", found, 1);
    ftdi_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_wr_low", wr0, 0);
    end
    ftdi_full = 1'b0;
    tick();
    chk("stall_resume", wr0, 1);
    drain("t4");

    // Fill with output blocked: one word sits in the serialiser, DEPTH in FIFO
    ftdi_full = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      chk("fill_ready", rdy0, (k <= DEPTH) ? 1 : 0);
      din       = rnd_word();
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      chk("fill_overflow", ovf0, (k > DEPTH) ? 1 : 0);
    end
    chk("fill_level", lvl0, DEPTH);
    chk("fill_q_bytes", 64'(q0.size()), (DEPTH + 1) * NB);
    ftdi_full = 1'b0;
    drain("t5");

    // Reset mid-word with two words queued
    for (int i = 0; i < 3; i++) begin
      din       = rnd_word();
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    cnt   = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (wr0) cnt++;
      if (cnt == 2) found = 1;
      else tick();
    end
    chk("rst_found_byte2", found, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    chk("midrst_wr_en", wr0, 0);
    chk("midrst_level", lvl0, 0);
    chk("midrst_overflow", ovf0, 0);
    chk("midrst_ready", rdy0, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_quiet_level", lvl0, 0);
    push_word(rnd_word());
    drain("t6");

    // Random traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      din       = rnd_word();
      din_valid = ($urandom_range(0, 1) == 1);
      ftdi_full = ($urandom_range(0, 4) == 0);
      tick();
    end
    din_valid = 1'b0;
    ftdi_full = 1'b0;
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
